// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the two-input gate self-test checker.
// Holds the checker state enum and the reference truth tables.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit k is the expected gate output for stim == k, with stim = {a, b}.
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector into a combinational gate, waits SETTLE cycles,
// samples its output against a latched truth table and reports pass/err_cnt/first failure.
module gate_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   truth_tbl,
  input  logic                 resp,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_idx
);
  import gate_sweep_pkg::*;

  localparam int NVEC = 2**N_IN;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW   = N_IN + 1;

  state_t            state, state_n;
  logic [N_IN-1:0]   idx;
  logic [CW-1:0]     cnt;
  logic [NVEC-1:0]   truth_q;
  logic              settle_last;
  logic              idx_last;
  logic              mismatch;

  assign settle_last = (cnt == CW'(SETTLE - 1));
  assign idx_last    = (idx == N_IN'(NVEC - 1));
  assign mismatch    = (resp != truth_q[idx]);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = APPLY;
      APPLY:   if (settle_last) state_n = SAMPLE;
      SAMPLE:  state_n = idx_last ? DONE : APPLY;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      truth_q         <= '0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            truth_q         <= truth_tbl;
            idx             <= '0;
            cnt             <= '0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
          end
        end
        APPLY: begin
          cnt <= settle_last ? '0 : cnt + CW'(1);
        end
        SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + EW'(1);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= idx;
            end
          end
          // pass must already reflect the final vector while done is high
          if (idx_last) pass <= (err_cnt == '0) && !mismatch;
          else          idx  <= idx + N_IN'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == APPLY) || (state == SAMPLE);
  assign done = (state == DONE);
  assign stim = busy ? idx : '0;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a behavioural gate drives resp,
// a model of each sweep is queued at start and compared when done appears.
module tb_gate_sweep_checker;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, resp0, resp1;
  logic [3:0] truth_tbl;
  int         gmode;
  logic [1:0] stim0, stim1, fei0, fei1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fev0, fev1;
  logic [2:0] err0, err1;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic       fev;
    logic [1:0] fei;
  } res_t;

  res_t sb[$];
  int errors = 0;
  int checks = 0;

  // 0: NOR, 1: AND, 2: stuck at 0, 3: stuck at 1
  function automatic logic gate_f(input int m, input logic [1:0] s);
    case (m)
      0:       return ~(s[1] | s[0]);
      1:       return s[1] & s[0];
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign resp0 = gate_f(gmode, stim0);
  assign resp1 = gate_f(gmode, stim1);

  gate_sweep_checker #(.N_IN(2), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .truth_tbl(truth_tbl), .resp(resp0),
    .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_valid(fev0), .first_err_idx(fei0)
  );

  gate_sweep_checker #(.N_IN(2), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .truth_tbl(truth_tbl), .resp(resp1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_valid(fev1), .first_err_idx(fei1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else           start1 = v;
  endtask

  task automatic observe(input int inst, output logic [1:0] s, output logic b, output logic d,
                         output logic p, output logic [2:0] e, output logic v,
                         output logic [1:0] i);
    if (inst == 0) begin
      s = stim0; b = busy0; d = done0; p = pass0; e = err0; v = fev0; i = fei0;
    end else begin
      s = stim1; b = busy1; d = done1; p = pass1; e = err1; v = fev1; i = fei1;
    end
  endtask

  task automatic check_results(input string tag, input res_t r, input logic p,
                               input logic [2:0] e, input logic v, input logic [1:0] i);
    check({tag, ".pass"}, 32'(p), 32'(r.pass));
    check({tag, ".err_cnt"}, 32'(e), 32'(r.err));
    check({tag, ".first_err_valid"}, 32'(v), 32'(r.fev));
    check({tag, ".first_err_idx"}, 32'(i), 32'(r.fei));
  endtask

  // extra: 0 plain, 1 second start + truth_tbl change mid-sweep and start during done, 2 reset at edge 5
  task automatic run_sweep(input int inst, input logic [3:0] tt, input int gm, input int extra);
    int   settle;
    int   total;
    res_t r;
    res_t got;
    logic [1:0] s, i;
    logic b, d, p, v;
    logic [2:0] e;

    settle = (inst == 0) ? 1 : 3;
    total  = 4 * (settle + 1);
    r.err = 3'd0; r.fev = 1'b0; r.fei = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (gate_f(gm, 2'(k)) !== tt[k]) begin
        r.err = r.err + 3'd1;
        if (!r.fev) begin
          r.fev = 1'b1;
          r.fei = 2'(k);
        end
      end
    end
    r.pass = (r.err == 3'd0);
    if (extra != 2) sb.push_back(r);

    gmode = gm;
    truth_tbl = tt;
    @(negedge clk);
    set_start(inst, 1'b1);
    @(posedge clk);
    for (int ed = 0; ed <= total; ed++) begin
      @(negedge clk);
      if (ed == 0) set_start(inst, 1'b0);
      observe(inst, s, b, d, p, e, v, i);
      if (extra == 2 && ed == 5) begin
        check("rst.busy", 32'(b), 32'd0);
        check("rst.stim", 32'(s), 32'd0);
        check("rst.err_cnt", 32'(e), 32'd0);
        check("rst.done", 32'(d), 32'd0);
        rst = 1'b0;
        break;
      end
      if (ed < total) begin
        check("sweep.stim", 32'(s), 32'(ed / (settle + 1)));
        check("sweep.busy", 32'(b), 32'd1);
        check("sweep.done", 32'(d), 32'd0);
      end else begin
        check("end.done", 32'(d), 32'd1);
        check("end.busy", 32'(b), 32'd0);
        check("end.stim", 32'(s), 32'd0);
        if (d && sb.size() > 0) begin
          got = sb.pop_front();
          check_results("end", got, p, e, v, i);
        end
      end
      if (extra == 2 && ed == 4) rst = 1'b1;
      if (extra == 1 && ed == 2) set_start(inst, 1'b1);
      if (extra == 1 && ed == 3) begin
        set_start(inst, 1'b0);
        truth_tbl = AND_TT;
      end
      if (extra == 1 && ed == total) set_start(inst, 1'b1);
    end

    if (extra == 2) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        observe(inst, s, b, d, p, e, v, i);
        check("rst.no_done", 32'(d), 32'd0);
      end
    end else begin
      @(negedge clk);
      set_start(inst, 1'b0);
      observe(inst, s, b, d, p, e, v, i);
      check("idle.busy", 32'(b), 32'd0);
      check("idle.done", 32'(d), 32'd0);
      check_results("hold", r, p, e, v, i);
      check("sb.empty", 32'(sb.size()), 32'd0);
      while (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] s, i;
    logic b, d, p, v;
    logic [2:0] e;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; truth_tbl = 4'd0; gmode = 0;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      observe(n, s, b, d, p, e, v, i);
      check("reset.stim", 32'(s), 32'd0);
      check("reset.busy", 32'(b), 32'd0);
      check("reset.done", 32'(d), 32'd0);
      check("reset.pass", 32'(p), 32'd0);
      check("reset.err_cnt", 32'(e), 32'd0);
      check("reset.first_err_valid", 32'(v), 32'd0);
      check("reset.first_err_idx", 32'(i), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_sweep(0, NOR_TT, 0, 0);
    run_sweep(0, NOR_TT, 1, 0);
    run_sweep(0, NOR_TT, 2, 0);
    run_sweep(0, NOR_TT, 3, 0);
    run_sweep(0, NOR_TT, 0, 1);
    run_sweep(0, NOR_TT, 0, 2);
    run_sweep(0, NOR_TT, 0, 0);
    run_sweep(0, XOR_TT, 1, 0);
    run_sweep(1, NOR_TT, 0, 0);
    run_sweep(1, NAND_TT, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-test stage for the team's two-input combinational gate blocks (a, b -> c). On a start pulse it sweeps every input combination into the gate under test and waits a programmable settle time. It then samples the gate output and compares it against a truth table supplied at start. It reports a pass flag, a mismatch count and the first failing vector. It sits directly upstream of the gate (it drives a, b) and directly downstream of it (it consumes c), so the gate-library testbenches can become a synthesizable checker.

## Interface
- N_IN, 2: number of gate inputs; sweeps 2**N_IN vectors.
- SETTLE, 1: cycles each vector is held before sampling; legal range >= 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- truth_tbl  in  2**N_IN  expected output; bit k = expected resp for stim == k; latched when start is accepted.
- resp  in  1  gate output (c).
- stim  out  N_IN  gate inputs; for N_IN=2, stim[1]=a and stim[0]=b.
- busy  out  1  high from the cycle after start acceptance through the last SAMPLE cycle.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  err_cnt == 0; valid from done until the next accepted start.
- err_cnt  out  N_IN+1  number of mismatching vectors.
- first_err_valid  out  1  at least one mismatch has occurred.
- first_err_idx  out  N_IN  lowest failing vector index; 0 when first_err_valid=0.

## Operation
- The FSM has four states: IDLE, APPLY, SAMPLE and DONE.
- IDLE:
  - With start=1, latch truth_tbl, clear err_cnt, pass, first_err_valid and first_err_idx, set idx=0, and go to APPLY.
  - With start=0, stay in IDLE.
- APPLY:
  - stim=idx; the settle counter runs for SETTLE cycles, then the FSM goes to SAMPLE.
- SAMPLE:
  - stim=idx is held.
  - If resp != truth_q[idx], increment err_cnt. If this is the first mismatch, also set first_err_valid=1 and first_err_idx=idx.
  - If idx == 2**N_IN-1, go to DONE. Otherwise increment idx and go to APPLY.
- DONE:
  - done=1 for one cycle and pass=(err_cnt==0), then go to IDLE.
  - Results hold until the next accepted start.
- Arithmetic and width rules:
  - err_cnt never exceeds 2**N_IN and never wraps or saturates.
  - idx wrap-around is never reached, because the sweep terminates on the last index.
- start is ignored in APPLY, SAMPLE and DONE. A start in the same cycle as done is ignored; it must be re-issued in IDLE.
- truth_tbl changes after acceptance have no effect on the sweep in progress.
- In IDLE and DONE, stim holds 0.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_idx=0, FSM in IDLE.
- Reset mid-sweep: on the edge sampling rst=1, all outputs return to their reset values, the sweep is abandoned and no done is issued.
- Edge 0 is the edge that samples start=1 in IDLE.
- Vector k: stim=k from edge k*(SETTLE+1) until edge (k+1)*(SETTLE+1). resp is sampled at edge (k+1)*(SETTLE+1)-1+1, i.e. the edge that ends the SAMPLE cycle.
- The gate path from stim to resp must settle within SETTLE cycles; it is purely combinational.
- done is high in the cycle following edge 2**N_IN*(SETTLE+1); for the defaults this is edge 8.
- err_cnt and first_err are updated on the edge closing each SAMPLE cycle. pass is updated at the DONE edge.
- All outputs are registered; none are combinational from inputs.

## Structure
- Shared package gate_sweep_pkg contains:
  - the state enum: IDLE, APPLY, SAMPLE, DONE;
  - two-input truth-table constants: NOR_TT=4'b0001, OR_TT=4'b1110, AND_TT=4'b1000, NAND_TT=4'b0111, XOR_TT=4'b0110, XNOR_TT=4'b1001.
- No sub-module: the FSM, settle counter, index counter and result registers live in one module.
- The gate under test is instantiated beside the checker, never inside it.

## Test plan
- Defaults, truth_tbl=NOR_TT, resp from a correct NOR -> stim sequence 0,0,1,1,2,2,3,3; done at edge 8; pass=1; err_cnt=0; first_err_valid=0.
- truth_tbl=NOR_TT, gate is an AND -> mismatches at idx 0 and 3; err_cnt=2; first_err_idx=0; pass=0.
- truth_tbl=NOR_TT, resp stuck at 0 -> err_cnt=1, first_err_idx=0. resp stuck at 1 -> err_cnt=3, first_err_idx=1.
- Second start pulse at edge 3 plus truth_tbl switched to AND_TT mid-sweep -> both ignored; done still at edge 8; results match the NOR run.
- rst at edge 5 -> the following cycle has busy=0, stim=0, err_cnt=0 and no done; a new start completes a full, correct sweep.
- SETTLE=3 with a correct NOR -> each stim value is held 4 cycles; done at edge 16; pass=1.
